// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         TIMEOUT_W         = 24;

endpackage

// File: rtl/boot_word_asm.sv
// Collects four bytes, least significant first, into one 32-bit word.
// word_vld and word are combinational on the fourth byte so the parent
// can register them into its memory write port in the same edge.
module boot_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  input  logic        clr,
  output logic        word_vld,
  output logic [31:0] word
);

  logic [1:0]  idx_q;
  logic [23:0] low_q;

  assign word_vld = byte_vld && (idx_q == 2'd3);
  assign word     = {byte_data, low_q};

  // Byte index and the three lower bytes of the word under construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
      low_q <= 24'd0;
    end else if (clr) begin
      idx_q <= 2'd0;
    end else if (byte_vld) begin
      idx_q <= idx_q + 2'd1;
      case (idx_q)
        2'd0:    low_q[7:0]   <= byte_data;
        2'd1:    low_q[15:8]  <= byte_data;
        2'd2:    low_q[23:16] <= byte_data;
        default: low_q        <= low_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Parses a framed boot image from the UART byte stream, writes the data
// words into instruction memory and releases the CPU reset once the
// frame checksum matches.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int         ADDR_W      = 14,
  parameter int         BASE_ADDR   = 0,
  parameter int         TIMEOUT_CYC = 1048576,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              clr_rdy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              boot_done,
  output logic              boot_err,
  output logic              busy
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST  = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]          MAX_WORDS = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]    BASE      = ADDR_W'(BASE_ADDR);

  boot_state_t          state_q, state_d;
  logic [15:0]          cnt_q;
  logic [7:0]           chk_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [15:0]          len_full;
  logic                 active, tmo_hit, start, err_set;
  logic                 word_vld;
  logic [31:0]          word;

  assign clr_rdy   = rx_rdy;
  assign boot_done = (state_q == DONE);
  assign cpu_rst_n = boot_done;
  assign busy      = (state_q != SYNC) && (state_q != DONE);
  assign active    = busy;
  assign tmo_hit   = active && !rx_rdy && (tmo_q == TMO_LAST);
  assign len_full  = {rx_data, cnt_q[7:0]};

  boot_word_asm u_word_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_vld  (rx_rdy && (state_q == DATA)),
    .byte_data (rx_data),
    .clr       (state_q != DATA),
    .word_vld  (word_vld),
    .word      (word)
  );

  // Frame parser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // Next-state decode; an arriving byte takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    err_set = 1'b0;
    if (tmo_hit) begin
      state_d = SYNC;
      err_set = 1'b1;
    end else if (rx_rdy) begin
      case (state_q)
        SYNC: begin
          if (rx_data == SYNC_BYTE) begin
            start   = 1'b1;
            state_d = LEN_LO;
          end
        end
        LEN_LO: state_d = LEN_HI;
        LEN_HI: begin
          if ({16'd0, len_full} > MAX_WORDS) begin
            err_set = 1'b1;
            state_d = SYNC;
          end else if (len_full == 16'd0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (word_vld && (cnt_q == 16'd1)) state_d = CHK;
        end
        CHK: begin
          if (rx_data == chk_q) begin
            state_d = DONE;
          end else begin
            err_set = 1'b1;
            state_d = SYNC;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = SYNC;
      endcase
    end
  end

  // Datapath: word count, checksum, timeout and memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 16'd0;
      chk_q     <= 8'd0;
      tmo_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 32'd0;
      boot_err  <= 1'b0;
    end else begin
      mem_we <= word_vld;
      if (word_vld) mem_wdata <= word;

      if (start)       mem_addr <= BASE;
      else if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);

      if (start)        boot_err <= 1'b0;
      else if (err_set) boot_err <= 1'b1;

      if (start) begin
        chk_q <= 8'd0;
      end else if (rx_rdy && (state_q == LEN_LO || state_q == LEN_HI || state_q == DATA)) begin
        chk_q <= chk_q ^ rx_data;
      end

      if (rx_rdy && state_q == LEN_LO)      cnt_q[7:0]  <= rx_data;
      else if (rx_rdy && state_q == LEN_HI) cnt_q[15:8] <= rx_data;
      else if (word_vld)                    cnt_q       <= cnt_q - 16'd1;

      if (rx_rdy || !active || tmo_hit) tmo_q <= '0;
      else                              tmo_q <= tmo_q + TIMEOUT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: a frame-level reference model
// is stepped alongside the DUT and compared every cycle.
module tb_uart_boot_loader;

  localparam int ADDR_W  = 14;
  localparam int BASE    = 0;
  localparam int TMO     = 64;
  localparam int MAXLEN  = (1 << ADDR_W) - BASE;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              clr_rdy, mem_we, cpu_rst_n, boot_done, boot_err, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_phase;   // 0 hunt, 1 header, 2 data, 3 checksum, 4 loaded
  logic [7:0] m_q[$];
  int         m_len, m_addr, m_idle;
  logic       m_we, m_err;
  logic [31:0] m_wdata;

  int         wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0] tx_q[$];

  uart_boot_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .clr_rdy(clr_rdy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .boot_done(boot_done),
    .boot_err(boot_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_phase = 0; m_q.delete(); m_len = 0; m_addr = BASE; m_idle = 0;
    m_we = 1'b0; m_err = 1'b0; m_wdata = 32'd0;
  endtask

  // Frame-level view: bytes after the sync marker are queued and interpreted
  // by their position in the frame.
  task automatic modelStep(input logic rdy, input logic [7:0] d);
    int n;
    logic [7:0] x;
    if (m_we) begin
      m_addr = (m_addr + 1) % (1 << ADDR_W);
      m_we = 1'b0;
    end
    if (!rdy) begin
      if (m_phase >= 1 && m_phase <= 3) begin
        m_idle++;
        if (m_idle == TMO) begin m_err = 1'b1; m_phase = 0; m_idle = 0; end
      end else m_idle = 0;
    end else begin
      m_idle = 0;
      case (m_phase)
        0: if (d == 8'hA5) begin
             m_phase = 1; m_q.delete(); m_err = 1'b0; m_addr = BASE;
           end
        1: begin
             m_q.push_back(d);
             if (m_q.size() == 2) begin
               m_len = int'(m_q[1]) * 256 + int'(m_q[0]);
               if (m_len > MAXLEN) begin m_err = 1'b1; m_phase = 0; end
               else if (m_len == 0) m_phase = 3;
               else m_phase = 2;
             end
           end
        2: begin
             m_q.push_back(d);
             n = m_q.size();
             if ((n - 2) % 4 == 0) begin
               m_we = 1'b1;
               m_wdata = {m_q[n-1], m_q[n-2], m_q[n-3], m_q[n-4]};
               if ((n - 2) / 4 == m_len) m_phase = 3;
             end
           end
        3: begin
             x = 8'd0;
             foreach (m_q[i]) x ^= m_q[i];
             if (d == x) m_phase = 4;
             else begin m_err = 1'b1; m_phase = 0; end
           end
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput();
    checkVal("clr_rdy",   {31'd0, clr_rdy},   {31'd0, rx_rdy});
    checkVal("mem_we",    {31'd0, mem_we},    {31'd0, m_we});
    checkVal("mem_addr",  32'(mem_addr),      32'(m_addr));
    checkVal("mem_wdata", mem_wdata,          m_wdata);
    checkVal("boot_done", {31'd0, boot_done}, {31'd0, m_phase == 4});
    checkVal("cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, m_phase == 4});
    checkVal("boot_err",  {31'd0, boot_err},  {31'd0, m_err});
    checkVal("busy",      {31'd0, busy},      {31'd0, m_phase >= 1 && m_phase <= 3});
  endtask

  // Per-cycle comparison against the model, plus a log of observed writes.
  always @(negedge clk) begin
    checkOutput();
    if (mem_we === 1'b1) begin
      wr_addr.push_back(32'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic cycle(input logic rdy, input logic [7:0] d);
    rx_rdy = rdy; rx_data = d;
    @(posedge clk);
    if (rst_n) modelStep(rdy, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic doReset();
    rst_n = 1'b0; rx_rdy = 1'b0; modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int gap_max);
    foreach (tx_q[i]) begin
      cycle(1'b1, tx_q[i]);
      idle($urandom_range(0, gap_max));
    end
    tx_q.delete();
  endtask

  task automatic pushFrame(input int len, input logic [7:0] chk_flip);
    logic [7:0] c, b;
    c = 8'(len) ^ 8'(len >> 8);
    tx_q.push_back(8'hA5); tx_q.push_back(8'(len)); tx_q.push_back(8'(len >> 8));
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom); tx_q.push_back(b); c ^= b;
    end
    tx_q.push_back(c ^ chk_flip);
  endtask

  initial begin
    int w0, kind, len;
    logic [7:0] g;
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; modelReset();
    doReset();
    checkVal("reset mem_addr", 32'(mem_addr), 32'd0);
    checkVal("reset cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    checkVal("reset boot_err", {31'd0, boot_err}, 32'd0);

    // Two-word frame; its checksum is 0x28
    w0 = wr_addr.size();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    applyStimulus(2);
    idle(3);
    checkVal("good writes", 32'(wr_addr.size() - w0), 32'd2);
    if (wr_addr.size() >= w0 + 2) begin
      checkVal("w0 addr", 32'(wr_addr[w0]), 32'd0);
      checkVal("w0 data", wr_data[w0], 32'h12345678);
      checkVal("w1 addr", 32'(wr_addr[w0+1]), 32'd1);
      checkVal("w1 data", wr_data[w0+1], 32'hDEADBEEF);
    end
    checkVal("good done", {31'd0, boot_done}, 32'd1);
    checkVal("good cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

    // Bytes after loading are acknowledged but change nothing
    w0 = wr_addr.size();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    applyStimulus(0);
    idle(2);
    checkVal("post-done writes", 32'(wr_addr.size() - w0), 32'd0);
    checkVal("post-done done", {31'd0, boot_done}, 32'd1);

    // Wrong checksum, then resend
    doReset();
    w0 = wr_addr.size();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h03};
    applyStimulus(1);
    idle(2);
    checkVal("badchk writes", 32'(wr_addr.size() - w0), 32'd2);
    checkVal("badchk err", {31'd0, boot_err}, 32'd1);
    checkVal("badchk cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    tx_q = '{8'hA5};
    applyStimulus(0);
    checkVal("err cleared by sync", {31'd0, boot_err}, 32'd0);
    tx_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    applyStimulus(1);
    idle(2);
    checkVal("resend done", {31'd0, boot_done}, 32'd1);

    // Leading garbage and a zero-length frame
    doReset();
    w0 = wr_addr.size();
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    applyStimulus(1);
    idle(2);
    checkVal("zero-len done", {31'd0, boot_done}, 32'd1);
    checkVal("zero-len writes", 32'(wr_addr.size() - w0), 32'd0);

    // Stall mid-word until the timeout fires
    doReset();
    w0 = wr_addr.size();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    applyStimulus(0);
    idle(TMO + 4);
    checkVal("timeout err", {31'd0, boot_err}, 32'd1);
    checkVal("timeout busy", {31'd0, busy}, 32'd0);
    checkVal("timeout writes", 32'(wr_addr.size() - w0), 32'd0);

    // Length one past the memory size is rejected, exact size is accepted
    doReset();
    tx_q = '{8'hA5, 8'h01, 8'h40};
    applyStimulus(0);
    checkVal("len 0x4001 err", {31'd0, boot_err}, 32'd1);
    tx_q = '{8'hA5, 8'h00, 8'h40};
    applyStimulus(0);
    checkVal("len 0x4000 busy", {31'd0, busy}, 32'd1);
    checkVal("len 0x4000 err", {31'd0, boot_err}, 32'd0);
    idle(TMO + 2);

    // Reset in the middle of a frame
    doReset();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11};
    applyStimulus(0);
    doReset();
    checkVal("midreset busy", {31'd0, busy}, 32'd0);
    checkVal("midreset cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);

    // Randomized frames: garbage, bad checksums, truncation
    for (int f = 0; f < 40; f++) begin
      if (m_phase == 4 || $urandom_range(0, 7) == 0) doReset();
      kind = $urandom_range(0, 9);
      len  = $urandom_range(0, 5);
      if (kind < 2) begin
        for (int i = 0; i < 3; i++) begin
          g = 8'($urandom);
          if (g == 8'hA5) g = 8'h00;
          tx_q.push_back(g);
        end
      end
      pushFrame(len, (kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00);
      if (kind == 3) begin
        tx_q = tx_q[0:$urandom_range(1, tx_q.size() - 2)];
        applyStimulus(3);
        idle(TMO + 3);
      end else begin
        applyStimulus(3);
        idle($urandom_range(1, 4));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
